adxl362_responder: RTL
======================

# adxl362_responder

SPI slave model of the ADXL362 accelerometer register interface, the responder end of the PmodACL2 SPI link. It decodes write (0x0A) and read (0x0B) instructions with auto-incrementing addresses, serves ID, status and XYZ data registers, and stores configuration writes. It provides synthesizable hardware-in-the-loop emulation of the sensor, so the alarm-system accelerometer driver can run on-board without a Pmod attached.

## Interface
- No parameters.
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- SCLK  input  1  SPI clock from master; asynchronous, idles low (mode 0).
- MOSI  input  1  SPI data from master, MSB first.
- CS  input  1  chip select, active low; asynchronous.
- MISO  output  1  SPI data to master, registered.
- sample_valid  input  1  one-cycle strobe: new sample on sample_x/y/z.
- sample_x, sample_y, sample_z  input  12 each  signed two's-complement acceleration.
- power_ctl  output  8  current contents of register 0x2D.
- measuring  output  1  power_ctl[1:0] == 2'b10.
- busy  output  1  synchronized CS is low.

## Operation
- SCLK, MOSI and CS each pass through 2-FF synchronizers. SCLK rise/fall and CS fall/rise are edge-detected on the synchronized signals.
- SPI mode 0: MOSI is sampled on each SCLK rise, and MISO is updated on each SCLK fall. Bit counter is 3 bits; a byte completes on the 8th rise.
- FSM states:
  - IDLE: CS high. On CS fall -> INSTR.
  - INSTR: on byte complete, 0x0A -> ADDR (write), 0x0B -> ADDR (read), any other value -> IGNORE.
  - ADDR: on byte complete, addr <= byte[5:0] (bits 7:6 ignored) -> DATA.
  - DATA (read): on the first SCLK fall after each byte boundary, the shift register is loaded with reg[addr] and MISO = bit 7, then addr increments. Subsequent falls shift out the remaining bits.
  - DATA (write): on byte complete, the byte is written to addr if writable, and addr increments.
  - IGNORE: holds until CS rise; MISO = 0.
- CS rise in any state -> IDLE within the same cycle it is detected. A partial byte is discarded and not written.
- Address wraps 0x3F -> 0x00.
- MISO = 0 in IDLE, INSTR, ADDR and IGNORE.
- Register map (reads):
  - 0x00 = 0xAD, 0x01 = 0x1D, 0x02 = 0xF2, 0x03 = 0x00.
  - 0x0B STATUS = {7'b0, data_ready}.
  - 0x0E..0x13 = XL, XH, YL, YH, ZL, ZH. L = value[7:0]; H = {4{value[11]}, value[11:8]}.
  - 0x20..0x2E = 15-byte writable file.
  - All other addresses read 0x00.
- Writes outside 0x20..0x2E are ignored, but the address still increments.
- Sample path:
  - sample_valid is accepted only while measuring = 1; otherwise it is dropped.
  - With CS high, an accepted sample loads the data registers directly and sets data_ready.
  - With CS low, an accepted sample goes to a pending buffer, which is copied on CS rise, so a burst always reads a coherent XYZ set. A newer pending sample overwrites an older one.
  - data_ready clears on the CS rise that ends any read burst that read address 0x0E..0x13.
  - A sample and a clear on the same CS rise: the sample wins and data_ready = 1.

## Timing
- Reset values: MISO 0, power_ctl 0x00, measuring 0, busy 0. Writable file, data registers, pending buffer and data_ready all 0. FSM is IDLE, addr is 0.
- Synchronizer latency is 2 cycles; edge detect adds 1 cycle. Requirements on the SPI master:
  - SCLK high and low phases ≥ 4 Clock cycles each.
  - CS setup to first SCLK rise ≥ 4 cycles; CS hold after last SCLK fall ≥ 4 cycles.
- MISO changes 3–4 Clock cycles after the SCLK fall that causes it.
- A register write takes effect 1 cycle after byte-complete detection. power_ctl and measuring update in that same cycle.
- A burst may read a register written earlier in the same burst and gets the new value.
- Reset asserted mid-transaction: everything returns to reset values next cycle. A following CS-low period without a fresh CS fall is ignored until CS rises and falls again.

## Test plan
- ID read: CS low, send 0x0B 0x00 then three dummy bytes, CS high -> MISO bytes 0xAD, 0x1D, 0xF2.
- Configure: send 0x0A 0x2D 0x22 -> power_ctl = 0x22, measuring = 1. Read 0x2D back -> 0x22.
- Data burst:
  - With measuring = 1, pulse sample x = 0x7FF, y = 0x800, z = 0x001, then read 0x0E ×6 -> 0xFF 0x07 0x00 0xF8 0x01 0x00.
  - STATUS = 0x01 before the burst and 0x00 after CS rise.
- Coherence: sample A loaded; sample B pulsed after the XL byte is read -> burst returns all-A; a following burst returns all-B.
- Boundaries:
  - Write burst starting at 0x2E with 3 bytes -> only 0x2E is changed, 0x2F/0x30 are unchanged.
  - Read starting at 0x3F, 2 bytes -> 0x00 then 0xAD (wrap).
  - Instruction 0x55 -> MISO stays 0, no register changes.
- Abort and reset:
  - CS rises after 4 bits of a write data byte -> target register is unchanged.
  - Reset pulse mid-read -> MISO = 0, power_ctl = 0x00 next cycle.
  - measuring = 0 -> sample_valid is dropped and STATUS stays 0x00.

Source files
------------

// File: rtl/adxl362_responder.sv
// adxl362_responder: SPI-slave emulation of the ADXL362 register interface
module adxl362_responder (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS,
  output logic        MISO,
  input  logic        sample_valid,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  output logic [7:0]  power_ctl,
  output logic        measuring,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, INSTR, ADDR, DATA, IGNORE} state_t;
  state_t state, state_n;
  logic [2:0] sclk_r, cs_r;
  logic [1:0] mosi_r, vld;
  logic armed;
  logic [2:0] cnt;
  logic [6:0] rx, tx;
  logic [7:0] rx_byte, rd_val;
  logic [5:0] addr;
  logic rd, rd_xyz, data_ready, pend_v;
  logic [11:0] dx, dy, dz, px, py, pz;
  logic [7:0] wfile [15];
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done, load, wr_byte, in_file, accept;
  assign sclk_rise = sclk_r[1] & ~sclk_r[2];
  assign sclk_fall = ~sclk_r[1] & sclk_r[2];
  assign cs_rise = cs_r[1] & ~cs_r[2];
  assign cs_fall = armed & ~cs_r[1] & cs_r[2];
  assign rx_byte = {rx, mosi_r[1]};
  assign byte_done = sclk_rise & (cnt == 3'd7);
  assign load = (state == DATA) & rd & sclk_fall & (cnt == 3'd0);
  assign wr_byte = (state == DATA) & ~rd & byte_done;
  assign in_file = (addr >= 6'h20) & (addr <= 6'h2E);
  assign accept = sample_valid & measuring;
  assign busy = ~cs_r[1];
  assign power_ctl = wfile[13];
  assign measuring = power_ctl[1:0] == 2'b10;
  // Synchronizers; armed only after a genuine CS-high is seen, so a CS held low across reset is not a fresh fall
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sclk_r <= 3'b000;
      mosi_r <= 2'b00;
      cs_r <= 3'b111;
      vld <= 2'b00;
      armed <= 1'b0;
    end else begin
      sclk_r <= {sclk_r[1:0], SCLK};
      mosi_r <= {mosi_r[0], MOSI};
      cs_r <= {cs_r[1:0], CS};
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & cs_r[1]);
    end
  end
  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else state <= state_n;
  end
  // FSM next state
  always_comb begin
    state_n = state;
    if (cs_rise) state_n = IDLE;
    else if (state == IDLE) state_n = cs_fall ? INSTR : IDLE;
    else if (byte_done)
      state_n = state == INSTR ? ((rx_byte == 8'h0A || rx_byte == 8'h0B) ? ADDR : IGNORE)
              : state == ADDR ? DATA : state;
  end
  // Register read map
  always_comb begin
    rd_val = 8'h00;
    case (addr)
      6'h00: rd_val = 8'hAD;
      6'h01: rd_val = 8'h1D;
      6'h02: rd_val = 8'hF2;
      6'h0B: rd_val = {7'b0, data_ready};
      6'h0E: rd_val = dx[7:0];
      6'h0F: rd_val = {{4{dx[11]}}, dx[11:8]};
      6'h10: rd_val = dy[7:0];
      6'h11: rd_val = {{4{dy[11]}}, dy[11:8]};
      6'h12: rd_val = dz[7:0];
      6'h13: rd_val = {{4{dz[11]}}, dz[11:8]};
      default: rd_val = in_file ? wfile[addr[3:0]] : 8'h00;
    endcase
  end
  // SPI shifting, address handling, register writes and MISO
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= 3'd0;
      rx <= 7'd0;
      tx <= 7'd0;
      addr <= 6'd0;
      rd <= 1'b0;
      MISO <= 1'b0;
      rd_xyz <= 1'b0;
      for (int i = 0; i < 15; i++) wfile[i] <= 8'h00;
    end else begin
      if (state == IDLE || cs_rise) cnt <= 3'd0;
      else if (sclk_rise) cnt <= cnt + 3'd1;
      if (sclk_rise) rx <= rx_byte[6:0];
      if (state == INSTR && byte_done) rd <= rx_byte[0];
      if (state == ADDR && byte_done) addr <= rx_byte[5:0];
      else if (load || wr_byte) addr <= addr + 6'd1;
      if (wr_byte && in_file) wfile[addr[3:0]] <= rx_byte;
      if (state != DATA || cs_rise) MISO <= 1'b0;
      else if (load) begin
        MISO <= rd_val[7];
        tx <= rd_val[6:0];
      end else if (rd && sclk_fall) begin
        MISO <= tx[6];
        tx <= {tx[5:0], 1'b0};
      end
      rd_xyz <= cs_rise ? 1'b0 : rd_xyz | (load & (addr >= 6'h0E) & (addr <= 6'h13));
    end
  end
  // Sample capture: direct when idle, buffered during a burst and copied on CS rise
  always_ff @(posedge Clock) begin
    if (Reset) begin
      {dx, dy, dz, px, py, pz} <= '0;
      pend_v <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      if (accept && busy) {px, py, pz} <= {sample_x, sample_y, sample_z};
      pend_v <= (accept & busy) | (pend_v & ~cs_rise);
      if (accept && !busy) {dx, dy, dz} <= {sample_x, sample_y, sample_z};
      else if (cs_rise && pend_v) {dx, dy, dz} <= {px, py, pz};
      data_ready <= ((accept && !busy) || (cs_rise && pend_v)) ? 1'b1
                  : (cs_rise && rd_xyz) ? 1'b0 : data_ready;
    end
  end
endmodule
